// File: rtl/integral_image_buffer_if.sv
// Pixel-stream and random-access read bundle of the integral image buffer.
// The pixel source / classifier side is the master, the buffer is the slave.
interface integral_image_buffer_if #(
    parameter int PIX_W  = 4,
    parameter int DATA_W = 21,
    parameter int ADDR_W = 15
);
    logic                     pix_valid;
    logic                     pix_sof;
    logic [PIX_W-1:0]         pix_data;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] data_out;
    logic                     frame_done;
    logic                     busy;

    modport master (
        output pix_valid, pix_sof, pix_data, rd_addr,
        input  data_out, frame_done, busy
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, rd_addr,
        output data_out, frame_done, busy
    );
endinterface

// File: rtl/integral_image_buffer.sv
// Builds a frame's integral image from a raster pixel stream into on-chip
// memory and serves random-access reads with a fixed 3-cycle latency.
module integral_image_buffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int PIX_W  = 4,
    parameter int DATA_W = 21,
    parameter int ADDR_W = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    integral_image_buffer_if.slave  bus
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int X_W   = $clog2(WIDTH);
    localparam int Y_W   = $clog2(HEIGHT);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [X_W-1:0]    X_LAST  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(HEIGHT - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_next;
    logic [X_W-1:0]    x, pos_x;
    logic [Y_W-1:0]    y, pos_y;
    logic [DATA_W-1:0] rowsum, rowsum_new, above, ii;
    logic [ADDR_W-1:0] wr_addr;
    logic              start, accept, last, wr_en;
    logic              frame_done_q;

    logic [DATA_W-1:0] line_buf [WIDTH];
    logic [DATA_W-1:0] mem      [DEPTH];

    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_hit_q;
    logic [DATA_W-1:0] mem_q, data_out_q;

    // A start-of-frame pixel always lands at (0,0), even in the middle of a frame.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_next = state;
        start      = bus.pix_valid && bus.pix_sof;
        accept     = start || (state == FILL && bus.pix_valid);
        pos_x      = start ? '0 : x;
        pos_y      = start ? '0 : y;
        last       = accept && pos_x == X_LAST && pos_y == Y_LAST;
        wr_en      = accept && !rst;

        rowsum_new = ((pos_x == '0) ? '0 : rowsum) + DATA_W'(bus.pix_data);
        above      = (pos_y == '0) ? '0 : line_buf[pos_x];
        ii         = rowsum_new + above;
        wr_addr    = ADDR_W'(pos_y) * ADDR_W'(WIDTH) + ADDR_W'(pos_x);

        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (last) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            rowsum       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= last;
            if (accept) begin
                rowsum <= rowsum_new;
                if (pos_x == X_LAST) begin
                    x <= '0;
                    y <= last ? '0 : pos_y + 1'b1;
                end else begin
                    x <= pos_x + 1'b1;
                    y <= pos_y;
                end
            end
        end
    end

    // NOTE: frame memory and line buffer are deliberately left out of reset;
    // every location is rewritten before it is meaningful for a new frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr]    <= ii;
            line_buf[pos_x] <= ii;
        end
    end

    // Read pipeline: address register, synchronous memory read, output register.
    // A read colliding with a write in the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q  <= '0;
            rd_hit_q   <= 1'b0;
            mem_q      <= '0;
            data_out_q <= '0;
        end else begin
            rd_addr_q  <= bus.rd_addr;
            rd_hit_q   <= rd_addr_q < DEPTH_A;
            mem_q      <= mem[rd_addr_q];
            data_out_q <= rd_hit_q ? mem_q : '0;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state == FILL);
endmodule
